// File: rtl/pattern_lut_loader_pkg.sv
// Shared constants and state encoding for the CCLUT pattern LUT loader.
package pattern_lut_loader_pkg;

  // Comparator-code width, which is also the LUT address width
  localparam int MXPATC  = 11;
  // pid field width on the register interface
  localparam int MXPIDB  = 4;
  // Bend field: 4-bit value plus L/R
  localparam int MXBNDB  = 5;
  // Offset code field
  localparam int MXOFFSB = 4;
  // One LUT word is {offset, bend}
  localparam int MXDATB  = MXBNDB + MXOFFSB;
  // Number of pattern LUTs (pid 0..4)
  localparam int NLUT    = 5;
  // Width of the running write checksum
  localparam int MXSUMB  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADR  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_CLEAR   = 3'd4
  } lut_state_t;

endpackage

// File: rtl/pattern_lut_loader.sv
// Host-side writer/readback engine for the five CCLUT pattern LUTs.
// Turns VME register strobes into auto-incrementing RAM writes/reads on one
// RAM port; the pattern lookup side uses the other port of each LUT RAM.
module pattern_lut_loader
  import pattern_lut_loader_pkg::*;
#(
  parameter int MXADRB = MXPATC,
  parameter int LUTW   = MXDATB,
  parameter int NLUTS  = NLUT,
  parameter int PIDW   = MXPIDB
) (
  input  logic                   clock,
  input  logic                   global_reset,
  input  logic                   lut_sel_wr,
  input  logic [PIDW-1:0]        lut_pid,
  input  logic [MXADRB-1:0]      lut_adr,
  input  logic                   lut_data_wr,
  input  logic [LUTW-1:0]        lut_wdata,
  input  logic                   lut_rd_req,
  input  logic                   lut_clear,
  output logic [LUTW-1:0]        lut_rdata,
  output logic                   lut_rd_valid,
  output logic                   lut_busy,
  output logic [MXSUMB-1:0]      lut_sum,
  output logic                   lut_err,
  output logic [NLUTS-1:0]       ram_we,
  output logic [MXADRB-1:0]      ram_adr,
  output logic [LUTW-1:0]        ram_wdata,
  input  logic [NLUTS*LUTW-1:0]  ram_rdata
);

  localparam int PIDIXB = (NLUTS > 1) ? $clog2(NLUTS) : 1;

  lut_state_t          state;
  logic [PIDW-1:0]     ptr_pid;
  logic [MXADRB-1:0]   ptr_adr;

  logic [LUTW-1:0]     rd_word [NLUTS];
  logic [PIDIXB-1:0]   pid_idx;
  logic                pid_ok;
  logic                any_strobe;

  // Split the flat RAM read bus into one word per LUT
  for (genvar gi = 0; gi < NLUTS; gi++) begin : g_unpack
    assign rd_word[gi] = ram_rdata[gi*LUTW +: LUTW];
  end

  assign pid_idx    = ptr_pid[PIDIXB-1:0];
  assign pid_ok     = (lut_pid < PIDW'(NLUTS));
  assign any_strobe = lut_sel_wr | lut_data_wr | lut_rd_req | lut_clear;

  // Loader FSM with pointer, checksum, error flag and registered RAM port.
  // WRITE accepts strobes exactly like IDLE, so back-to-back writes stream.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state        <= ST_IDLE;
      ptr_pid      <= '0;
      ptr_adr      <= '0;
      lut_rdata    <= '0;
      lut_rd_valid <= 1'b0;
      lut_busy     <= 1'b0;
      lut_sum      <= '0;
      lut_err      <= 1'b0;
      ram_we       <= '0;
      ram_adr      <= '0;
      ram_wdata    <= '0;
    end else begin
      ram_we       <= '0;
      lut_rd_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_WRITE: begin
          state    <= ST_IDLE;
          lut_busy <= 1'b0;
          if (lut_clear) begin
            state     <= ST_CLEAR;
            lut_busy  <= 1'b1;
            ram_we    <= '1;
            ram_adr   <= '0;
            ram_wdata <= '0;
            if (lut_sel_wr | lut_data_wr | lut_rd_req) lut_err <= 1'b1;
          end else if (lut_sel_wr) begin
            if (pid_ok) begin
              ptr_pid <= lut_pid;
              ptr_adr <= lut_adr;
              lut_sum <= '0;
              // A good select clears the error unless it dropped a strobe
              lut_err <= lut_data_wr | lut_rd_req;
            end else begin
              lut_err <= 1'b1;
            end
          end else if (lut_data_wr) begin
            state     <= ST_WRITE;
            ram_we    <= NLUTS'(1) << ptr_pid;
            ram_adr   <= ptr_adr;
            ram_wdata <= lut_wdata;
            ptr_adr   <= ptr_adr + MXADRB'(1);
            lut_sum   <= lut_sum + MXSUMB'(lut_wdata);
            if (lut_rd_req) lut_err <= 1'b1;
          end else if (lut_rd_req) begin
            state    <= ST_RD_ADR;
            lut_busy <= 1'b1;
            ram_adr  <= ptr_adr;
            ptr_adr  <= ptr_adr + MXADRB'(1);
          end
        end
        ST_RD_ADR: begin
          state <= ST_RD_WAIT;
          if (any_strobe) lut_err <= 1'b1;
        end
        ST_RD_WAIT: begin
          state        <= ST_IDLE;
          lut_busy     <= 1'b0;
          lut_rdata    <= rd_word[pid_idx];
          lut_rd_valid <= 1'b1;
          if (any_strobe) lut_err <= 1'b1;
        end
        ST_CLEAR: begin
          if (any_strobe) lut_err <= 1'b1;
          if (ram_adr == '1) begin
            state    <= ST_IDLE;
            lut_busy <= 1'b0;
            ptr_pid  <= '0;
            ptr_adr  <= '0;
            lut_sum  <= '0;
          end else begin
            ram_we  <= '1;
            ram_adr <= ram_adr + MXADRB'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          lut_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_lut_loader.sv
// Directed self-checking bench for pattern_lut_loader with a behavioural
// five-LUT RAM on the loader port and a scoreboard of expected writes/reads.
module tb_pattern_lut_loader;

  logic          clock = 1'b0;
  logic          global_reset = 1'b1;
  logic          lut_sel_wr = 1'b0;
  logic [3:0]    lut_pid = '0;
  logic [10:0]   lut_adr = '0;
  logic          lut_data_wr = 1'b0;
  logic [8:0]    lut_wdata = '0;
  logic          lut_rd_req = 1'b0;
  logic          lut_clear = 1'b0;
  logic [8:0]    lut_rdata;
  logic          lut_rd_valid;
  logic          lut_busy;
  logic [15:0]   lut_sum;
  logic          lut_err;
  logic [4:0]    ram_we;
  logic [10:0]   ram_adr;
  logic [8:0]    ram_wdata;
  logic [44:0]   ram_rdata;

  pattern_lut_loader dut (
    .clock(clock), .global_reset(global_reset),
    .lut_sel_wr(lut_sel_wr), .lut_pid(lut_pid), .lut_adr(lut_adr),
    .lut_data_wr(lut_data_wr), .lut_wdata(lut_wdata),
    .lut_rd_req(lut_rd_req), .lut_clear(lut_clear),
    .lut_rdata(lut_rdata), .lut_rd_valid(lut_rd_valid), .lut_busy(lut_busy),
    .lut_sum(lut_sum), .lut_err(lut_err),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural LUT RAMs: one write port per LUT, 1-cycle registered read
  logic [8:0] mem [5][2048];
  initial begin
    for (int k = 0; k < 5; k++)
      for (int a = 0; a < 2048; a++) mem[k][a] = '0;
    ram_rdata = '0;
  end
  always @(posedge clock) begin
    for (int k = 0; k < 5; k++) begin
      if (ram_we[k]) mem[k][ram_adr] <= ram_wdata;
      ram_rdata[k*9 +: 9] <= mem[k][ram_adr];
    end
  end

  typedef struct { logic [4:0] we; logic [10:0] adr; logic [8:0] d; int cyc; } wexp_t;
  typedef struct { logic [8:0] d; int cyc; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit in_clear = 0;

  // Reference model state
  logic [8:0]  shadow [5][2048];
  int          m_pid = 0;
  logic [10:0] m_adr = '0;
  logic [15:0] m_sum = '0;
  logic        m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any RAM write or readback pulse against the scoreboard
  task automatic mon();
    wexp_t w;
    rexp_t r;
    if (ram_we !== 5'd0 && !in_clear) begin
      if (wq.size() == 0) check("unexpected_we", 32'(ram_we), 32'd0);
      else begin
        w = wq.pop_front();
        check("we", 32'(ram_we), 32'(w.we));
        check("we_adr", 32'(ram_adr), 32'(w.adr));
        check("we_data", 32'(ram_wdata), 32'(w.d));
        check("we_cycle", 32'(cyc), 32'(w.cyc));
        $display("write  cyc=%0d we=%b adr=%h data=%h", cyc, ram_we, ram_adr, ram_wdata);
      end
    end
    if (lut_rd_valid !== 1'b0) begin
      if (rq.size() == 0) check("unexpected_rd_valid", 32'(lut_rd_valid), 32'd0);
      else begin
        r = rq.pop_front();
        check("rdata", 32'(lut_rdata), 32'(r.d));
        check("rd_cycle", 32'(cyc), 32'(r.cyc));
        $display("read   cyc=%0d rdata=%h", cyc, lut_rdata);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    mon();
  endtask

  task automatic do_sel(input int pid, input logic [10:0] adr);
    lut_pid = 4'(pid);
    lut_adr = adr;
    lut_sel_wr = 1'b1;
    if (pid < 5) begin
      m_pid = pid; m_adr = adr; m_sum = '0; m_err = 1'b0;
    end else m_err = 1'b1;
    tick();
    lut_sel_wr = 1'b0;
    $display("sel    cyc=%0d pid=%0d adr=%h err=%b", cyc, pid, adr, lut_err);
  endtask

  task automatic do_write(input logic [8:0] d);
    wexp_t w;
    lut_data_wr = 1'b1;
    lut_wdata = d;
    w.we = 5'(1 << m_pid); w.adr = m_adr; w.d = d; w.cyc = cyc + 1;
    wq.push_back(w);
    shadow[m_pid][m_adr] = d;
    m_adr = m_adr + 11'd1;
    m_sum = m_sum + 16'(d);
    tick();
    lut_data_wr = 1'b0;
  endtask

  task automatic push_read();
    rexp_t r;
    r.d = shadow[m_pid][m_adr];
    r.cyc = cyc + 3;
    rq.push_back(r);
    m_adr = m_adr + 11'd1;
  endtask

  task automatic do_read();
    lut_rd_req = 1'b1;
    push_read();
    tick();
    lut_rd_req = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sum"}, 32'(lut_sum), 32'(m_sum));
    check({tag, "_err"}, 32'(lut_err), 32'(m_err));
    check({tag, "_busy"}, 32'(lut_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, 32'(lut_rdata), 32'd0);
    check({tag, "_valid"}, 32'(lut_rd_valid), 32'd0);
    check({tag, "_busy"}, 32'(lut_busy), 32'd0);
    check({tag, "_sum"}, 32'(lut_sum), 32'd0);
    check({tag, "_err"}, 32'(lut_err), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_adr"}, 32'(ram_adr), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  int sweep_bad;
  logic [8:0] last_rd;

  initial begin
    for (int k = 0; k < 5; k++)
      for (int a = 0; a < 2048; a++) shadow[k][a] = '0;

    // Reset
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    global_reset = 1'b0;
    tick();

    // Write three words into pid 2 across the address wrap
    do_sel(2, 11'h7FE);
    check_regs("sel2");
    do_write(9'h1A5);
    check("busy_in_write", 32'(lut_busy), 32'd0);
    do_write(9'h0F3);
    do_write(9'h101);
    tick();
    check_regs("after_writes");

    // Read them back, spaced four cycles apart
    do_sel(2, 11'h7FE);
    for (int i = 0; i < 3; i++) begin
      do_read();
      check("rd_busy1", 32'(lut_busy), 32'd1);
      tick();
      check("rd_busy2", 32'(lut_busy), 32'd1);
      tick();
      check("rd_busy3", 32'(lut_busy), 32'd0);
      tick();
    end
    last_rd = 9'h101;
    tick(); tick();
    check("rdata_hold", 32'(lut_rdata), 32'(last_rd));

    // Bad pid leaves the pointer alone and sets the sticky error
    do_sel(5, 11'h123);
    check_regs("bad_pid");
    do_write(9'h055);
    tick();
    check_regs("write_after_bad_pid");
    do_sel(0, 11'h010);
    check_regs("good_pid_clears_err");
    do_write(9'h1FF);
    do_write(9'h0AA);
    tick();
    check_regs("pid0_writes");
    do_sel(0, 11'h010);
    do_read(); tick(); tick(); tick();
    do_read(); tick(); tick(); tick();
    do_sel(2, 11'h001);
    do_read(); tick(); tick(); tick();

    // Read strobe while busy is ignored and flags an error
    do_sel(0, 11'h010);
    lut_rd_req = 1'b1;
    push_read();
    tick();
    m_err = 1'b1;
    tick();
    lut_rd_req = 1'b0;
    tick(); tick();
    check_regs("rd_while_busy");

    // Clear with a simultaneous write: clear runs, write dropped
    lut_clear = 1'b1;
    lut_data_wr = 1'b1;
    lut_wdata = 9'h0C3;
    in_clear = 1;
    m_err = 1'b1;
    tick();
    lut_clear = 1'b0;
    lut_data_wr = 1'b0;
    sweep_bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (!(ram_we === 5'h1F && ram_adr === 11'(i) && ram_wdata === 9'h000 && lut_busy === 1'b1))
        sweep_bad++;
      if (i == 5) lut_rd_req = 1'b1;
      if (i < 2047) tick();
      lut_rd_req = 1'b0;
    end
    check("clear_sweep_bad_cycles", 32'(sweep_bad), 32'd0);
    tick();
    in_clear = 0;
    for (int k = 0; k < 5; k++)
      for (int a = 0; a < 2048; a++) shadow[k][a] = '0;
    m_pid = 0; m_adr = '0; m_sum = '0;
    check_regs("after_clear");
    check("after_clear_we", 32'(ram_we), 32'd0);

    // Pointer is 0/0 after clear; readback of cleared words is zero
    do_write(9'h077);
    tick();
    do_sel(2, 11'h7FE);
    check_regs("sel_after_clear");
    do_read(); tick(); tick(); tick();
    do_sel(0, 11'h000);
    do_read(); tick(); tick(); tick();
    do_read(); tick(); tick(); tick();

    // Reset in the middle of a clear sweep
    lut_clear = 1'b1;
    in_clear = 1;
    tick();
    lut_clear = 1'b0;
    repeat (499) tick();
    #2 global_reset = 1'b1;
    #1 check_all_zero("reset_mid_clear");
    @(negedge clock);
    global_reset = 1'b0;
    in_clear = 0;
    m_pid = 0; m_adr = '0; m_sum = '0; m_err = 1'b0;
    tick();
    check_regs("after_mid_reset");
    do_write(9'h1C3);
    tick();
    check_regs("write_after_reset");
    do_sel(0, 11'h000);
    do_read(); tick(); tick(); tick();

    check("write_queue_drained", 32'(wq.size()), 32'd0);
    check("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
